// File: rtl/accum5b_pkg.sv
// Shared definitions for the accum5b frame accumulator: FSM state encoding
// and default sizing constants used by the top and the bench.
package accum5b_pkg;

    // Frame FSM: IDLE waits for the first operand, ACC sums the rest,
    // DONE holds the result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 5;
    localparam int DEF_N_OPS = 4;

    // Largest value representable in 'width' bits (saturation ceiling).
    function automatic int max_val(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/add5_rca.sv
// Combinational WIDTH-bit ripple-carry adder built from full_adder1b cells.
// The carry out of the top cell is exported so the caller can flag overflow.
module add5_rca #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[WIDTH];

    // Chain one full adder per bit, carry rippling from LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder1b u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
        );
    end

endmodule

// File: rtl/full_adder1b.sv
// One-bit full adder cell; the building block of the ripple-carry adder.
module full_adder1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;

    // Propagate term shared by the sum and carry equations.
    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/accum5b_seq.sv
// Frame accumulator: sums N_OPS unsigned operands into a WIDTH-bit result
// with a sticky carry-out flag, then presents the result on an output
// handshake.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A producer holding valid keeps its data stable until the transfer; the
// result side (out_valid/out_sum/out_ovf) is held stable here until
// out_ready is seen with out_valid.
//
// Optional build macro ACCUM5B_SAT_EN: any carry-out clamps the running
// sum to all-ones and keeps it there for the rest of the frame. Without it
// the sum wraps modulo 2^WIDTH.
module accum5b_seq
    import accum5b_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_OPS = DEF_N_OPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output state_t           dbg_state
);

    localparam int CNT_W = $clog2(N_OPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             out_valid_q;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] acc_upd;

    // The first operand of a frame is added to zero, so the adder's A input
    // is forced to zero in IDLE rather than relying on acc being cleared.
    assign add_a   = (state == IDLE) ? '0 : acc;
    assign cnt_inc = cnt + ONE_CNT;

    add5_rca #(.WIDTH(WIDTH)) u_add (
        .a   (add_a),
        .b   (in_data),
        .cin (1'b0),
        .sum (add_sum),
        .cout(add_cout)
    );

    // Accumulator update for an ACC-state accept: wrap or saturate.
`ifdef ACCUM5B_SAT_EN
    assign acc_upd = (add_cout || ovf) ? '1 : add_sum;
`else
    assign acc_upd = add_sum;
`endif

    // Ready is withheld while reset is asserted and while a result waits.
    assign in_ready  = !rst && (state != DONE);
    assign out_valid = out_valid_q;
    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign dbg_state = state;

    // Frame FSM with accumulator, sticky overflow and operand counter.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state       <= IDLE;
            acc         <= '0;
            ovf         <= 1'b0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= add_sum;
                        ovf   <= 1'b0;
                        cnt   <= ONE_CNT;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc <= acc_upd;
                        ovf <= ovf | add_cout;
                        cnt <= cnt_inc;
                        if (cnt_inc == LAST_CNT) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum5b_seq.sv
// Self-checking bench for accum5b_seq: directed frames for the documented
// corner cases followed by randomized frames, all compared against a
// frame-level arithmetic model.
module tb_accum5b_seq;
    import accum5b_pkg::*;

    localparam int WIDTH = 5;
    localparam int N_OPS = 4;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    state_t           dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] frame_q[$];
    logic [WIDTH:0]   exp_q[$];

    accum5b_seq #(.WIDTH(WIDTH), .N_OPS(N_OPS)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: a frame's result depends only on the operand total.
    // Every carry-out costs 2^WIDTH, so a carry happened iff total >= 2^WIDTH.
    task automatic end_frame();
        int total = 0;
        int s;
        logic ovf;
        foreach (frame_q[i]) total += int'(frame_q[i]);
        ovf = (total >= MOD);
`ifdef ACCUM5B_SAT_EN
        s = ovf ? MOD - 1 : total;
`else
        s = total % MOD;
`endif
        exp_q.push_back({ovf, s[WIDTH-1:0]});
        frame_q.delete();
    endtask

    // Drivers: called at a falling edge; return at a falling edge.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_op(input logic [WIDTH-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            frame_q.push_back(d);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < N_OPS; i++) begin
            send_op(WIDTH'($urandom_range(0, MOD - 1)));
            idle_cycles(gap);
        end
        end_frame();
    endtask

    // Wait for a result, hold it for 'hold' cycles with out_ready low, then take it.
    task automatic get_result(input string tag, input int hold);
        int n = 0;
        logic [WIDTH:0] exp;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_sum"}, 32'(out_sum), 32'(exp[WIDTH-1:0]));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(exp[WIDTH]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_sum"}, 32'(out_sum), 32'(exp[WIDTH-1:0]));
            check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_state"}, 32'(dbg_state), 32'(IDLE));
        check({tag, "_post_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        idle_cycles(2);
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(out_sum), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy_after", 32'(in_ready), 32'd1);

        // 3,5,7,9 back-to-back with out_ready high: one-cycle result pulse
        out_ready = 1'b1;
        send_op(5'd3);
        send_op(5'd5);
        send_op(5'd7);
        check("b2b_no_early_valid", 32'(out_valid), 32'd0);
        send_op(5'd9);
        end_frame();
        check("b2b_valid_lat1", 32'(out_valid), 32'd1);
        check("b2b_sum", 32'(out_sum), 32'(exp_q[0][WIDTH-1:0]));
        check("b2b_sum_const", 32'(out_sum), 32'd24);
        check("b2b_ovf", 32'(out_ovf), 32'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        check("b2b_pulse_end", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // 20,20,1,1: carry-out mid-frame
        send_op(5'd20);
        send_op(5'd20);
        send_op(5'd1);
        send_op(5'd1);
        end_frame();
`ifdef ACCUM5B_SAT_EN
        check("ovf_model_sum", 32'(exp_q[0][WIDTH-1:0]), 32'd31);
`else
        check("ovf_model_sum", 32'(exp_q[0][WIDTH-1:0]), 32'd10);
`endif
        get_result("ovf", 0);

        // 1,2,3,4 with two-cycle gaps; result held five cycles
        for (int i = 1; i <= 4; i++) begin
            send_op(WIDTH'(i));
            idle_cycles(2);
            if (i < 4) check("gap_state", 32'(dbg_state), 32'(ACC));
        end
        end_frame();
        get_result("gap_hold", 5);

        // Reset after two operands discards the partial frame
        send_op(5'd5);
        send_op(5'd5);
        frame_q.delete();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rdy", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        for (int i = 0; i < 4; i++) begin
            send_op(5'd1);
            if (i < 3) check("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        end_frame();
        get_result("midrst", 1);

        // clr with an operand presented the same cycle: operand ignored
        send_op(5'd10);
        send_op(5'd10);
        frame_q.delete();
        in_valid = 1'b1;
        in_data  = 5'd7;
        clr      = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_state", 32'(dbg_state), 32'(IDLE));
        check("clr_sum", 32'(out_sum), 32'd0);
        for (int i = 0; i < 4; i++) send_op(5'd2);
        end_frame();
        get_result("clr", 0);

        // clr in DONE wins over a same-cycle out_ready
        send_frame(0);
        idle_cycles(1);
        check("clrdone_valid_before", 32'(out_valid), 32'd1);
        clr       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        out_ready = 1'b0;
        check("clrdone_valid", 32'(out_valid), 32'd0);
        check("clrdone_state", 32'(dbg_state), 32'(IDLE));
        check("clrdone_ovf", 32'(out_ovf), 32'd0);
        void'(exp_q.pop_front());

        // Randomized frames with random gaps and hold times
        for (int f = 0; f < 40; f++) begin
            send_frame(int'($urandom_range(0, 2)));
            get_result("rand", int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
